pipe_ctrl: RTL

Pipeline stall/flush controller for the five-stage core. It takes stall requests from IF, ID, EX and MEM and drives a per-stage stall vector to the PC register and the pipeline registers. It sequences branch/exception redirects with a multi-cycle flush and PC reload. It also keeps saturating stall/flush performance counters and a stall watchdog.

---
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the five-stage core.
// Combines per-stage stall requests into a hold vector, sequences redirects
// as a multi-cycle flush with a one-cycle PC reload, and keeps saturating
// performance counters plus a sticky stall watchdog.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_MAX     = 1024,
  parameter int STALL_CNT_W  = 32,
  parameter int FLUSH_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   if_stallreq,
  input  logic                   id_stallreq,
  input  logic                   ex_stallreq,
  input  logic                   mem_stallreq,
  input  logic                   flush_req,
  input  logic [31:0]            flush_pc,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic [31:0]            new_pc,
  output logic                   new_pc_vld,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [FLUSH_CNT_W-1:0] flush_cnt,
  output logic                   stall_timeout
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [3:0]  FC    = 4'(FLUSH_CYCLES);
  localparam logic [15:0] WM    = 16'(WDOG_MAX);
  localparam logic [15:0] WM_M1 = 16'(WDOG_MAX - 1);

  state_t      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [4:0]  req_vec;
  logic        accept;
  logic [15:0] wd_q;

  function automatic logic [STALL_CNT_W-1:0] sat_inc_stall(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [FLUSH_CNT_W-1:0] sat_inc_flush(input logic [FLUSH_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Highest-stage requester wins; every upstream stage holds with it
  always_comb begin
    req_vec = 5'b00000;
    if (mem_stallreq)      req_vec = 5'b11111;
    else if (ex_stallreq)  req_vec = 5'b01111;
    else if (id_stallreq)  req_vec = 5'b00111;
    else if (if_stallreq)  req_vec = 5'b00011;
  end

  // Next-state and stall output; redirects are taken even while stalled
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    stall   = 6'b000000;
    accept  = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = {1'b0, req_vec};
        if (flush_req) begin
          accept  = 1'b1;
          state_d = ST_FLUSH;
          fcnt_d  = FC;
        end
      end
      ST_FLUSH: begin
        // flush_req is stale here: its source is being cleared
        fcnt_d = fcnt_q - 4'd1;
        if (fcnt_q <= 4'd1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign flush = (state_q == ST_FLUSH);

  // State register and flush-length counter
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_RUN;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Redirect target capture; valid strobe lasts the first flush cycle only
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      new_pc     <= 32'd0;
      new_pc_vld <= 1'b0;
    end else begin
      new_pc_vld <= accept;
      if (accept) new_pc <= flush_pc;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall[0]) stall_cnt <= sat_inc_stall(stall_cnt);
      if (accept)   flush_cnt <= sat_inc_flush(flush_cnt);
    end
  end

  // Watchdog over consecutive stalled RUN cycles; timeout is sticky
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wd_q          <= 16'd0;
      stall_timeout <= 1'b0;
    end else begin
      if (accept || !stall[0]) wd_q <= 16'd0;
      else if (wd_q != WM)     wd_q <= wd_q + 16'd1;
      if (stall[0] && !accept && (wd_q >= WM_M1)) stall_timeout <= 1'b1;
    end
  end

endmodule
